// File: rtl/fp_normalize_pkg.sv
// fp_normalize_pkg: shared constants and state encoding for the small-format FP add/sub normalizer.
package fp_normalize_pkg;
    localparam int EXP_W      = 3;
    localparam int MANT_W_DEF = 4;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_CHECK = 2'd1;
    localparam state_t S_DONE  = 2'd2;

    // Bit positions inside exp_diff_sign, shared with the exponent datapath
    localparam int SIGN_SUB = 1;
    localparam int SIGN_NZ  = 0;
endpackage

// File: rtl/fp_normalize.sv
// fp_normalize: sequential post-add normalizer, one shift per clock until the hidden bit is set.
module fp_normalize
    import fp_normalize_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [MANT_W+1:0] sum_in,
    input  logic [EXP_W-1:0]  exp_big,
    output logic [MANT_W-1:0] mant_norm,
    output logic [EXP_W-1:0]  exp_diff_norm,
    output logic [1:0]        exp_diff_sign,
    output logic              zero,
    output logic              underflow,
    output logic              busy,
    output logic              done
);
    state_t            state;
    logic [MANT_W+1:0] sr;
    logic [EXP_W-1:0]  cnt;
    logic              dir_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sr        <= '0;
            cnt       <= '0;
            dir_sub   <= 1'b0;
            zero      <= 1'b0;
            underflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    sr        <= sum_in;
                    cnt       <= '0;
                    dir_sub   <= 1'b0;
                    zero      <= 1'b0;
                    underflow <= 1'b0;
                    state     <= S_CHECK;
                end
                S_CHECK: if (sr[MANT_W+1]) begin
                    // Carry out: truncating right shift, no sticky bit
                    sr      <= sr >> 1;
                    cnt     <= EXP_W'(1);
                    dir_sub <= 1'b0;
                    state   <= S_DONE;
                end else if (sr[MANT_W]) begin
                    state <= S_DONE;
                end else if (sr == '0) begin
                    zero  <= 1'b1;
                    state <= S_DONE;
                end else if (cnt == exp_big) begin
                    underflow <= 1'b1;
                    state     <= S_DONE;
                end else begin
                    sr      <= sr << 1;
                    cnt     <= cnt + 1'b1;
                    dir_sub <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign mant_norm               = sr[MANT_W-1:0];
    assign exp_diff_norm           = cnt;
    assign exp_diff_sign[SIGN_SUB] = dir_sub;
    assign exp_diff_sign[SIGN_NZ]  = cnt != '0;
    assign busy                    = state == S_CHECK;
    assign done                    = state == S_DONE;
endmodule

// File: tb/tb_fp_normalize.sv
// tb_fp_normalize: scoreboard bench for fp_normalize with MANT_W = 4 directed vectors.
module tb_fp_normalize;
    import fp_normalize_pkg::*;
    localparam int MW = 4;

    typedef struct {
        logic [MW-1:0] mant;
        logic [2:0]    edn;
        logic [1:0]    sign;
        logic          zero;
        logic          uf;
        int            k;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [MW+1:0] sum_in = '0;
    logic [2:0]    exp_big = '0;
    logic [MW-1:0] mant_norm;
    logic [2:0]    exp_diff_norm;
    logic [1:0]    exp_diff_sign;
    logic          zero, underflow, busy, done;

    exp_t q[$];
    exp_t last;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    fp_normalize #(.MANT_W(MW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sum_in(sum_in), .exp_big(exp_big),
        .mant_norm(mant_norm), .exp_diff_norm(exp_diff_norm), .exp_diff_sign(exp_diff_sign),
        .zero(zero), .underflow(underflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no pulse at cycle %0d", cyc);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc + 1, e.due);
                chk("mant_norm", mant_norm, e.mant);
                chk("exp_diff_norm", exp_diff_norm, e.edn);
                chk("exp_diff_sign", exp_diff_sign, e.sign);
                chk("zero", zero, e.zero);
                chk("underflow", underflow, e.uf);
                chk("busy_in_done", busy, 0);
            end
        end
    end

    task automatic issue(input logic [MW+1:0] s, input logic [2:0] eb, input exp_t e);
        @(negedge clk);
        sum_in = s;
        exp_big = eb;
        start = 1'b1;
        e.due = cyc + 1 + 2 + e.k;
        q.push_back(e);
        last = e;
        @(negedge clk);
        start = 1'b0;
        chk("busy_in_check", busy, 1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done want done pending=%0d", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_hold(input string tag);
        chk({tag, "_mant"}, mant_norm, last.mant);
        chk({tag, "_edn"}, exp_diff_norm, last.edn);
        chk({tag, "_sign"}, exp_diff_sign, last.sign);
        chk({tag, "_zero"}, zero, last.zero);
        chk({tag, "_uf"}, underflow, last.uf);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        last = '{4'b0, 3'd0, 2'b00, 1'b0, 1'b0, 0, 0};
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_hold("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_hold("idle");

        issue(6'b10_1101, 3'd3, '{4'b0110, 3'd1, 2'b01, 1'b0, 1'b0, 0, 0});
        wait_empty();
        check_hold("carry_hold");
        issue(6'b01_1010, 3'd3, '{4'b1010, 3'd0, 2'b00, 1'b0, 1'b0, 0, 0});
        wait_empty();
        issue(6'b00_0101, 3'd5, '{4'b0100, 3'd2, 2'b11, 1'b0, 1'b0, 2, 0});
        wait_empty();
        issue(6'b00_0001, 3'd2, '{4'b0100, 3'd2, 2'b11, 1'b0, 1'b1, 2, 0});
        wait_empty();
        check_hold("uf_hold");
        issue(6'b00_0000, 3'd3, '{4'b0000, 3'd0, 2'b00, 1'b1, 1'b0, 0, 0});
        wait_empty();
        issue(6'b00_0011, 3'd0, '{4'b0011, 3'd0, 2'b00, 1'b0, 1'b1, 0, 0});
        wait_empty();
        issue(6'b00_0001, 3'd7, '{4'b0000, 3'd4, 2'b11, 1'b0, 1'b0, 4, 0});
        wait_empty();
        issue(6'b11_1111, 3'd0, '{4'b1111, 3'd1, 2'b01, 1'b0, 1'b0, 0, 0});
        wait_empty();

        // start pulsed while busy must not disturb the running result
        issue(6'b00_0101, 3'd5, '{4'b0100, 3'd2, 2'b11, 1'b0, 1'b0, 2, 0});
        sum_in = 6'b10_0000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        repeat (5) @(negedge clk);
        check_hold("busy_start");

        // start coinciding with done is dropped
        issue(6'b10_1101, 3'd3, '{4'b0110, 3'd1, 2'b01, 1'b0, 1'b0, 0, 0});
        for (int i = 0; i < 10 && !done; i++) @(negedge clk);
        chk("done_seen", done, 1);
        sum_in = 6'b01_1010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check_hold("done_start");

        // async reset in the middle of a two-shift normalization
        @(negedge clk);
        sum_in = 6'b00_0101;
        exp_big = 3'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("busy_before_rst", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        last = '{4'b0, 3'd0, 2'b00, 1'b0, 1'b0, 0, 0};
        check_hold("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_hold("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish by 200000");
        $fatal(1, "watchdog");
    end
endmodule
